multicore_sched: RTL and testbench
==================================

# multicore_sched

Round-robin scheduler between the single input sample stream / single output result stream and the NCORES parallel Taylor-series cores of the multicore network. It collects per-core sample requests, hands each upstream sample to exactly one requesting core, and merges the cores' result pulses into one back-pressured output stream tagged with the originating core index. It sits directly between the stimulus/result interfaces and the core array, replacing the bench-side OR of all request lines.

## Interface
- NCORES, 22, number of cores served
- DW_IN, 19, signed input sample width
- DW_OUT, 28, signed result width
- IW, 5, core index width, ≥ clog2(NCORES)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_data  in  DW_IN  signed upstream sample
- in_valid  in  1  in_data valid
- in_ready  out  1  sample accepted this cycle (in_valid & in_ready)
- req_in  in  4*NCORES  per-core request code, core i at bits [4i+3:4i]; code 4'd1 = request one sample
- core_data  out  DW_IN  sample broadcast to all cores
- core_load  out  NCORES  one-hot load strobe, core i latches core_data when bit i = 1
- core_out  in  DW_OUT*NCORES  per-core result, core i at [DW_OUT*i+DW_OUT-1:DW_OUT*i]
- out_en  in  4*NCORES  per-core result code; 4'd1 = core_out valid this cycle (1-cycle pulse)
- out_data  out  DW_OUT  merged signed result
- out_core  out  IW  index of core that produced out_data
- out_valid  out  1  out_data/out_core valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- overrun  out  1  sticky: a result pulse was lost

## Operation
- Request capture: req_pend[i] sets on any cycle req_in code i == 4'd1; all other codes ignored. Clears when core i is granted, unless code 4'd1 is present in that same cycle (set wins).
- Input grant: in_ready = |req_pend (combinational from registers). When in_valid & in_ready, grant g = first pending index searching in_ptr, in_ptr+1, … NCORES-1, 0, … (wrap). Register core_data <= in_data, core_load <= one-hot(g), in_ptr <= (g == NCORES-1) ? 0 : g+1. Otherwise core_load <= 0, core_data holds.
- Result capture: per-core holding register hold[i]/hold_v[i]. On out_en code i == 4'd1: if hold_v[i] = 0 or hold[i] is being drained this cycle, hold[i] <= core_out i, hold_v[i] <= 1; else new value dropped, old kept, overrun <= 1.
- Drain: output register updates when !out_valid | out_ready. Select first hold_v index from out_ptr with wrap; load out_data/out_core, out_valid <= 1, clear that hold_v (unless recaptured same cycle), out_ptr <= index+1 wrap. No hold_v set: out_valid <= 0.
- Signed values pass bit-exact; no arithmetic on data.
- overrun clears only on reset.

## Timing
- Reset (async assert, sync-to-clk release): core_load = 0, core_data = 0, out_valid = 0, out_data = 0, out_core = 0, overrun = 0, in_ready = 0, all pend/hold_v = 0, in_ptr = out_ptr = 0. Reset mid-transfer discards pending requests and held results.
- Request latency: req_in code 1 at edge t → req_pend at t+1 → earliest core_load pulse after edge t+2.
- Input throughput: one sample per cycle while requests pend; single outstanding request per core (repeated code 1 before grant collapses to one).
- Result latency: out_en at edge t → hold_v at t+1 → earliest out_valid after t+2.
- Output throughput: one result per cycle with out_ready held high. out_data/out_core stable while out_valid & !out_ready.
- Empty: in_ready low, in_valid ignored; no hold_v → out_valid drops after the accepted beat.

## Test plan
- Reset: drive rst_n low mid-stream with pending requests → all outputs 0 within the reset, no core_load after release until new requests.
- Round-robin input: cores 0, 5, 21 request at once, in_valid high with samples -7, 100, -262144 → core_load 0,5,21 in consecutive cycles with core_data -7, 100, -262144; in_ptr wraps to 0.
- Back-to-back repeat: core 3 requests every cycle, core 4 once → grants alternate 3,4,3,3…; code 4'd2 on core 6 never granted.
- Output merge: cores 1 and 20 pulse out_en with -134217728 and 134217727 same cycle, out_ready high → two beats, out_core 1 then 20, values exact.
- Back-pressure/overrun: out_ready low, core 2 pulses twice (5 then 9) → one beat of 5 once out_ready rises, overrun = 1, 9 never appears.
- Simultaneous drain and recapture on core 7 (values 11 then 12) → both beats delivered in order, overrun stays 0.

Source files
------------

// File: rtl/multicore_sched_if.sv
// -----------------------------------------------------------------------------
// multicore_sched_if
// Stream-side bundle of the multicore scheduler: the single upstream sample
// stream and the single merged, tagged result stream.
//
//   in_data   signed upstream sample
//   in_valid  in_data valid
//   in_ready  scheduler can accept a sample this cycle
//   out_data  merged signed result
//   out_core  index of the core that produced out_data
//   out_valid out_data/out_core valid
//   out_ready downstream accepts the current result
//
// modport master : the environment (sample source / result sink)
// modport slave  : the scheduler
// -----------------------------------------------------------------------------
interface multicore_sched_if #(
   parameter int DW_IN  = 19,
   parameter int DW_OUT = 28,
   parameter int IW     = 5
);
   logic signed [DW_IN-1:0]  in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DW_OUT-1:0] out_data;
   logic [IW-1:0]            out_core;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_core, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_core, out_valid
   );
endinterface

// File: rtl/multicore_sched.sv
// -----------------------------------------------------------------------------
// multicore_sched
// Round-robin scheduler between one sample stream / one result stream and
// NCORES parallel Taylor-series cores. Each upstream sample goes to exactly
// one requesting core; per-core result pulses are buffered one deep and merged
// into a single back-pressured output stream tagged with the core index.
//
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        stream interface (slave side), see multicore_sched_if
//   req_in     per-core 4-bit request code, code 1 = request one sample
//   core_data  sample broadcast to all cores
//   core_load  one-hot load strobe into the granted core
//   core_out   per-core result words
//   out_en     per-core 4-bit result code, code 1 = core_out valid (pulse)
//   overrun    sticky flag: a result pulse found its holding slot full
// -----------------------------------------------------------------------------
module multicore_sched #(
   parameter int NCORES = 22,
   parameter int DW_IN  = 19,
   parameter int DW_OUT = 28,
   parameter int IW     = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   multicore_sched_if.slave           bus,
   input  logic [4*NCORES-1:0]        req_in,
   output logic signed [DW_IN-1:0]    core_data,
   output logic [NCORES-1:0]          core_load,
   input  logic [DW_OUT*NCORES-1:0]   core_out,
   input  logic [4*NCORES-1:0]        out_en,
   output logic                       overrun
);

   localparam logic [3:0] CODE_ONE = 4'd1;

   logic [NCORES-1:0]        req_one;
   logic [NCORES-1:0]        en_one;
   logic [NCORES-1:0]        req_pend;
   logic [NCORES-1:0]        hold_v;
   logic signed [DW_OUT-1:0] hold [NCORES];
   logic [IW-1:0]            in_ptr;
   logic [IW-1:0]            out_ptr;
   logic [IW-1:0]            in_sel;
   logic [IW-1:0]            out_sel;
   logic                     in_fire;
   logic                     out_upd;
   logic                     drain_fire;
   logic [NCORES-1:0]        grant_vec;
   logic [NCORES-1:0]        drain_vec;
   logic [NCORES-1:0]        cap_vec;
   logic signed [DW_OUT-1:0] out_data_r;
   logic [IW-1:0]            out_core_r;
   logic                     out_valid_r;

   // First set bit of vec, searching ptr, ptr+1, ... NCORES-1, 0, ... ptr-1.
   // Walking k downwards lets the lowest distance from ptr overwrite last.
   function automatic logic [IW-1:0] rr_pick(input logic [NCORES-1:0] vec,
                                             input logic [IW-1:0]     ptr);
      logic [IW-1:0] pick;
      logic [IW-1:0] cand;
      pick = '0;
      for (int k = NCORES - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k >= NCORES) ? IW'(int'(ptr) + k - NCORES)
                                          : IW'(int'(ptr) + k);
         if (vec[cand]) pick = cand;
      end
      return pick;
   endfunction

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
      return (idx == IW'(NCORES - 1)) ? '0 : idx + 1'b1;
   endfunction

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      req_one = '0;
      en_one  = '0;
      for (int i = 0; i < NCORES; i++) begin
         req_one[i] = (req_in[4*i +: 4] == CODE_ONE);
         en_one[i]  = (out_en[4*i +: 4] == CODE_ONE);
      end
   end

   assign in_sel     = rr_pick(req_pend, in_ptr);
   assign out_sel    = rr_pick(hold_v, out_ptr);
   assign in_fire    = bus.in_valid & (|req_pend);
   assign out_upd    = ~out_valid_r | bus.out_ready;
   assign drain_fire = out_upd & (|hold_v);
   assign grant_vec  = in_fire    ? (NCORES'(1) << in_sel)  : '0;
   assign drain_vec  = drain_fire ? (NCORES'(1) << out_sel) : '0;
   // A slot accepts a new pulse when empty or when it empties this very cycle.
   assign cap_vec    = en_one & (~hold_v | drain_vec);

   // Input side: request capture and one-hot grant of the broadcast sample.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pend  <= '0;
         in_ptr    <= '0;
         core_load <= '0;
         core_data <= '0;
      end else begin
         // A fresh request in the grant cycle wins over the clear.
         req_pend  <= (req_pend & ~grant_vec) | req_one;
         core_load <= grant_vec;
         if (in_fire) begin
            core_data <= bus.in_data;
            in_ptr    <= wrap_inc(in_sel);
         end
      end
   end

   // Result side: holding-slot flags, overrun, and the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_v      <= '0;
         overrun     <= 1'b0;
         out_ptr     <= '0;
         out_data_r  <= '0;
         out_core_r  <= '0;
         out_valid_r <= 1'b0;
      end else begin
         hold_v <= (hold_v & ~drain_vec) | cap_vec;
         if (|(en_one & ~cap_vec)) overrun <= 1'b1;
         if (out_upd) begin
            if (|hold_v) begin
               out_data_r  <= hold[out_sel];
               out_core_r  <= out_sel;
               out_valid_r <= 1'b1;
               out_ptr     <= wrap_inc(out_sel);
            end else begin
               out_valid_r <= 1'b0;
            end
         end
      end
   end

   // NOTE: the holding data words carry no reset; hold_v alone says whether a
   // slot is meaningful, and reset already clears hold_v.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCORES; i++) begin
         if (cap_vec[i]) hold[i] <= core_out[DW_OUT*i +: DW_OUT];
      end
   end

   assign bus.in_ready  = |req_pend;
   assign bus.out_data  = out_data_r;
   assign bus.out_core  = out_core_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_multicore_sched.sv
// -----------------------------------------------------------------------------
// tb_multicore_sched
// Self-checking bench for multicore_sched: a reference model of the
// scheduling rules (arrays, modulo search) is stepped alongside the DUT every
// cycle, with explicit expectations for the directed corner cases and a
// stimulus table for the round-robin input case.
// -----------------------------------------------------------------------------
module tb_multicore_sched;
   localparam int NCORES = 22;
   localparam int DW_IN  = 19;
   localparam int DW_OUT = 28;
   localparam int IW     = 5;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [4*NCORES-1:0]      req_in;
   logic signed [DW_IN-1:0]  core_data;
   logic [NCORES-1:0]        core_load;
   logic [DW_OUT*NCORES-1:0] core_out;
   logic [4*NCORES-1:0]      out_en;
   logic                     overrun;

   multicore_sched_if #(.DW_IN(DW_IN), .DW_OUT(DW_OUT), .IW(IW)) bus ();

   multicore_sched #(.NCORES(NCORES), .DW_IN(DW_IN), .DW_OUT(DW_OUT), .IW(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .req_in    (req_in),
      .core_data (core_data),
      .core_load (core_load),
      .core_out  (core_out),
      .out_en    (out_en),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- reference model state ----------------
   bit                       m_pend [NCORES];
   bit                       m_hv   [NCORES];
   logic signed [DW_OUT-1:0] m_hold [NCORES];
   int                       m_in_ptr, m_out_ptr;
   logic [NCORES-1:0]        m_load;
   logic signed [DW_IN-1:0]  m_cdata;
   bit                       m_ov;
   logic signed [DW_OUT-1:0] m_odata;
   int                       m_ocore;
   bit                       m_overrun;

   typedef struct {
      logic [NCORES-1:0]       req;
      logic                    iv;
      logic signed [DW_IN-1:0] din;
      logic [NCORES-1:0]       exp_load;
      logic signed [DW_IN-1:0] exp_data;
      logic                    exp_ready;
   } vec_t;

   vec_t tbl [8];

   function automatic logic [NCORES-1:0] onehot(input int i);
      logic [NCORES-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int first_from(input bit v [NCORES], input int start);
      for (int k = 0; k < NCORES; k++) begin
         if (v[(start + k) % NCORES]) return (start + k) % NCORES;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCORES; i++) begin
         m_pend[i] = 0;
         m_hv[i]   = 0;
         m_hold[i] = '0;
      end
      m_in_ptr  = 0;
      m_out_ptr = 0;
      m_load    = '0;
      m_cdata   = '0;
      m_ov      = 0;
      m_odata   = '0;
      m_ocore   = 0;
      m_overrun = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int g, d;
      bit accept, upd, drained;
      g       = first_from(m_pend, m_in_ptr);
      d       = first_from(m_hv, m_out_ptr);
      accept  = bus.in_valid && (g >= 0);
      upd     = !m_ov || bus.out_ready;
      drained = upd && (d >= 0);

      m_load = '0;
      if (accept) begin
         m_load[g] = 1'b1;
         m_cdata   = bus.in_data;
         m_in_ptr  = (g + 1) % NCORES;
      end
      for (int i = 0; i < NCORES; i++) begin
         if (req_in[4*i +: 4] == 4'd1) m_pend[i] = 1;
         else if (accept && g == i)    m_pend[i] = 0;
      end

      if (upd) begin
         if (d >= 0) begin
            m_odata   = m_hold[d];
            m_ocore   = d;
            m_ov      = 1;
            m_out_ptr = (d + 1) % NCORES;
         end else begin
            m_ov = 0;
         end
      end
      for (int i = 0; i < NCORES; i++) begin
         if (out_en[4*i +: 4] == 4'd1) begin
            if (!m_hv[i] || (drained && d == i)) begin
               m_hold[i] = core_out[DW_OUT*i +: DW_OUT];
               m_hv[i]   = 1;
            end else begin
               m_overrun = 1;
            end
         end else if (drained && d == i) begin
            m_hv[i] = 0;
         end
      end
   endtask

   task automatic compare_model();
      bit any;
      any = 0;
      for (int i = 0; i < NCORES; i++) any |= m_pend[i];
      check("in_ready",  64'(bus.in_ready),  64'(any));
      check("core_load", 64'(core_load),     64'(m_load));
      check("core_data", 64'(core_data),     64'(m_cdata));
      check("out_valid", 64'(bus.out_valid), 64'(m_ov));
      check("out_data",  64'(bus.out_data),  64'(m_odata));
      check("out_core",  64'(bus.out_core),  64'(m_ocore));
      check("overrun",   64'(overrun),       64'(m_overrun));
   endtask

   // Inputs are set at the falling edge; outputs are checked at the next one.
   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   task automatic clear_inputs();
      req_in       = '0;
      out_en       = '0;
      core_out     = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
   endtask

   task automatic set_req(input int core, input logic [3:0] code);
      req_in[4*core +: 4] = code;
   endtask

   task automatic pulse(input int core, input logic signed [DW_OUT-1:0] val);
      out_en[4*core +: 4]        = 4'd1;
      core_out[DW_OUT*core +: DW_OUT] = val;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_core_load"}, 64'(core_load),     64'd0);
      check({tag, "_core_data"}, 64'(core_data),     64'd0);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_out_data"},  64'(bus.out_data),  64'd0);
      check({tag, "_out_core"},  64'(bus.out_core),  64'd0);
      check({tag, "_overrun"},   64'(overrun),       64'd0);
      check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
   endtask

   // Assert reset between edges, check outputs while held, release at a
   // falling edge.
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      model_reset();
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Round-robin input table: cores 0, 5, 21 request together, then 1, 20
      // after the pointer has wrapped back to 0.
      tbl[0] = '{req: onehot(0) | onehot(5) | onehot(21), iv: 1'b1, din: 19'sd1,
                 exp_load: '0, exp_data: 19'sd0, exp_ready: 1'b1};
      tbl[1] = '{req: '0, iv: 1'b1, din: -19'sd7,
                 exp_load: onehot(0), exp_data: -19'sd7, exp_ready: 1'b1};
      tbl[2] = '{req: '0, iv: 1'b1, din: 19'sd100,
                 exp_load: onehot(5), exp_data: 19'sd100, exp_ready: 1'b1};
      tbl[3] = '{req: '0, iv: 1'b1, din: 19'sh40000,
                 exp_load: onehot(21), exp_data: 19'sh40000, exp_ready: 1'b0};
      tbl[4] = '{req: '0, iv: 1'b1, din: 19'sd55,
                 exp_load: '0, exp_data: 19'sh40000, exp_ready: 1'b0};
      tbl[5] = '{req: onehot(1) | onehot(20), iv: 1'b0, din: 19'sd0,
                 exp_load: '0, exp_data: 19'sh40000, exp_ready: 1'b1};
      tbl[6] = '{req: '0, iv: 1'b1, din: 19'sd3,
                 exp_load: onehot(1), exp_data: 19'sd3, exp_ready: 1'b1};
      tbl[7] = '{req: '0, iv: 1'b1, din: 19'sd4,
                 exp_load: onehot(20), exp_data: 19'sd4, exp_ready: 1'b0};

      rst_n         = 1'b0;
      bus.out_ready = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;

      // ---- reset mid-stream with pending requests and a held result ----
      set_req(2, 4'd1);
      set_req(9, 4'd1);
      pulse(4, 28'sd77);
      step();
      clear_inputs();
      step();
      do_reset("mid_rst");
      bus.in_valid = 1'b1;
      bus.in_data  = 19'sd42;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("post_rst_load",  64'(core_load),     64'd0);
         check("post_rst_ready", 64'(bus.in_ready),  64'd0);
         check("post_rst_ovalid", 64'(bus.out_valid), 64'd0);
      end
      clear_inputs();

      // ---- output merge: extreme values, core 1 then core 20 ----
      bus.out_ready = 1'b1;
      pulse(1, 28'sh8000000);
      pulse(20, 28'sh7FFFFFF);
      step();
      clear_inputs();
      check("merge_idle", 64'(bus.out_valid), 64'd0);
      step();
      check("merge_v0", 64'(bus.out_valid), 64'd1);
      check("merge_c0", 64'(bus.out_core),  64'd1);
      check("merge_d0", 64'(bus.out_data),  64'(28'sh8000000));
      step();
      check("merge_c1", 64'(bus.out_core),  64'd20);
      check("merge_d1", 64'(bus.out_data),  64'(28'sh7FFFFFF));
      step();
      check("merge_end", 64'(bus.out_valid), 64'd0);

      // ---- simultaneous drain and recapture on core 7 ----
      pulse(7, 28'sd11);
      step();
      clear_inputs();
      pulse(7, 28'sd12);
      step();
      clear_inputs();
      check("recap_c0", 64'(bus.out_core), 64'd7);
      check("recap_d0", 64'(bus.out_data), 64'd11);
      step();
      check("recap_v1", 64'(bus.out_valid), 64'd1);
      check("recap_d1", 64'(bus.out_data),  64'd12);
      step();
      check("recap_end", 64'(bus.out_valid), 64'd0);
      check("recap_ovr", 64'(overrun),       64'd0);

      // ---- back-pressure and overrun on core 2 behind a stalled beat ----
      bus.out_ready = 1'b0;
      pulse(0, 28'sd1);
      step();
      clear_inputs();
      step();
      check("bp_fill", 64'(bus.out_core), 64'd0);
      pulse(2, 28'sd5);
      step();
      clear_inputs();
      pulse(2, 28'sd9);
      step();
      clear_inputs();
      check("bp_ovr",    64'(overrun),       64'd1);
      check("bp_stable", 64'(bus.out_data),  64'd1);
      bus.out_ready = 1'b1;
      step();
      check("bp_c", 64'(bus.out_core), 64'd2);
      check("bp_d", 64'(bus.out_data), 64'd5);
      step();
      check("bp_no9",    64'(bus.out_valid), 64'd0);
      check("bp_sticky", 64'(overrun),       64'd1);

      // ---- round-robin input table ----
      do_reset("rr_rst");
      foreach (tbl[n]) begin
         clear_inputs();
         for (int i = 0; i < NCORES; i++) if (tbl[n].req[i]) set_req(i, 4'd1);
         bus.in_valid = tbl[n].iv;
         bus.in_data  = tbl[n].din;
         step();
         check($sformatf("rr%0d_load", n),  64'(core_load),    64'(tbl[n].exp_load));
         check($sformatf("rr%0d_data", n),  64'(core_data),    64'(tbl[n].exp_data));
         check($sformatf("rr%0d_ready", n), 64'(bus.in_ready), 64'(tbl[n].exp_ready));
      end

      // ---- back-to-back repeat: core 3 every cycle, core 4 once ----
      do_reset("b2b_rst");
      set_req(3, 4'd1);
      set_req(4, 4'd1);
      set_req(6, 4'd2);
      bus.in_valid = 1'b1;
      bus.in_data  = 19'sd10;
      step();
      check("b2b_first", 64'(core_load), 64'd0);
      begin
         int exp_seq [4] = '{3, 4, 3, 3};
         for (int k = 0; k < 4; k++) begin
            clear_inputs();
            set_req(3, 4'd1);
            set_req(6, 4'd2);
            bus.in_valid = 1'b1;
            bus.in_data  = 19'(11 + k);
            step();
            check($sformatf("b2b_grant%0d", k), 64'(core_load), 64'(onehot(exp_seq[k])));
         end
      end
      clear_inputs();
      set_req(6, 4'd2);
      bus.in_valid = 1'b1;
      step();
      check("b2b_last", 64'(core_load), 64'(onehot(3)));
      step();
      check("b2b_c6_load",  64'(core_load),    64'd0);
      check("b2b_c6_ready", 64'(bus.in_ready), 64'd0);

      // ---- randomized traffic against the model ----
      for (int c = 0; c < 1500; c++) begin
         int r;
         clear_inputs();
         for (int i = 0; i < NCORES; i++) begin
            r = int'($urandom_range(0, 31));
            if (r < 3)       set_req(i, 4'd1);
            else if (r == 3) set_req(i, 4'($urandom_range(2, 15)));
            r = int'($urandom_range(0, 47));
            if (r == 0)      pulse(i, DW_OUT'($urandom));
            else if (r == 1) out_en[4*i +: 4] = 4'($urandom_range(2, 15));
            core_out[DW_OUT*i +: DW_OUT] = (r == 0) ? core_out[DW_OUT*i +: DW_OUT]
                                                    : DW_OUT'($urandom);
         end
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = DW_IN'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
